sprite_renderer: RTL and testbench
==================================

# sprite_renderer

Parametrised, pipelined tile-sprite colour generator for the VGA path. Takes a sprite ID and tile-local pixel coordinates each clock and produces a COLOR_WIDTH RGB pixel three cycles later. Each sprite has a runtime-writable palette entry of foreground colour, background colour and pattern mode: solid, checker, border or blink. A frame-pulse-driven animation phase drives the blink mode. Sits between the tile-map lookup and the VGA output register.

## Interface
- TILE_WIDTH, 32, tile width in pixels (power of two)
- TILE_HEIGHT, 32, tile height in pixels (power of two)
- ID_WIDTH, 4, sprite ID width; palette depth = 2**ID_WIDTH
- COLOR_WIDTH, 9, pixel width (3:3:3 RGB at default)
- CHECK_SHIFT, 2, coordinate bit selecting checker cell size (cell = 2**CHECK_SHIFT px)
- ANIM_FRAMES, 30, frame pulses per blink phase toggle (≥1)
- i_Clk  in  1  system clock; all logic on rising edge
- i_Rst_L  in  1  reset, asynchronous, active-low
- i_Valid  in  1  pixel request valid
- i_X  in  $clog2(TILE_WIDTH)  tile-local x
- i_Y  in  $clog2(TILE_HEIGHT)  tile-local y
- i_Sprite  in  ID_WIDTH  sprite ID
- i_Frame_Start  in  1  one-cycle pulse per video frame
- i_Pal_We  in  1  palette write enable
- i_Pal_Addr  in  ID_WIDTH  palette entry to write
- i_Pal_Data  in  2*COLOR_WIDTH+2  {mode[1:0], fg, bg}
- o_Pixel  out  COLOR_WIDTH  output colour
- o_Valid  out  1  o_Pixel valid

## Operation
- Modes: 00 SOLID → fg; 01 CHECKER → (X[CHECK_SHIFT]^Y[CHECK_SHIFT]) ? bg : fg; 10 BORDER → (X==0 | X==TILE_WIDTH-1 | Y==0 | Y==TILE_HEIGHT-1) ? fg : bg; 11 BLINK → phase ? bg : fg.
- Palette reset defaults, all mode SOLID, bg = fg: ID1 111_111_010; ID2 011_111_010; ID3 000_000_001; ID4 111_111_111; all other IDs 111_000_111. Defaults are scaled to COLOR_WIDTH by MSB-replicating each channel when COLOR_WIDTH ≠ 9.
- Palette write takes effect at the clock edge where i_Pal_We=1. A read of the same entry in the same cycle returns the old value.
- Animation: a frame counter of width $clog2(ANIM_FRAMES+1) increments on each i_Frame_Start. When the counter reaches ANIM_FRAMES-1 and i_Frame_Start is high, the counter wraps to 0 and phase toggles. Phase is sampled in stage 2.
- i_Valid=0 still flows through the pipeline. o_Valid=0 and o_Pixel holds its previous value.

## Timing
- Stage 1: register X, Y, valid and the palette entry read at i_Sprite.
- Stage 2: compute pattern bit and register it with fg/bg.
- Stage 3: select colour → o_Pixel, o_Valid.
- Latency is exactly 3 cycles, throughput 1 pixel/clock, no stall or backpressure.
- Reset (asynchronous assert, synchronous release by the upstream reset synchroniser):
  - o_Pixel = 0, o_Valid = 0
  - all pipeline valids 0
  - frame counter 0, phase 0
  - palette at defaults
- Reset mid-stream discards all in-flight pixels. The first valid output follows 3 cycles after the first post-reset i_Valid.
- i_Frame_Start and i_Pal_We in the same cycle are independent and both take effect.
- A palette write landing during a frame affects only pixels whose stage-1 read occurs after the write edge.

## Structure
- Shared package sprite_pkg:
  - mode constants MODE_SOLID / MODE_CHECKER / MODE_BORDER / MODE_BLINK
  - default colour constants COL_YELLOW, COL_LIME, COL_NAVY, COL_WHITE, COL_MAGENTA (9-bit)
  - palette-entry field offsets
- Sub-module sprite_palette holds the 2**ID_WIDTH × (2*COLOR_WIDTH+2) register file.
  - One synchronous write port and one registered read port, old data on collision.
  - Reset loads defaults.
- The animation counter, pattern logic and output pipeline stay in sprite_renderer.

## Test plan
- Reset, then i_Valid=1, i_Sprite=1 for 4 cycles → o_Valid rises exactly 3 cycles after the first request; o_Pixel=111_111_010. ID 9 → 111_000_111.
- Write ID5 = {01, fg 000_111_000, bg 111_000_000}, then sweep X=0..7 at Y=0 → fg for X 0-3, bg for X 4-7. At Y=4, X=0 → bg.
- Write ID6 BORDER, fg 111_111_111, bg 000_000_000 → (0,0), (31,5), (7,31) return white; (1,1) and (30,30) return black.
- Write ID7 BLINK, fg≠bg, with ANIM_FRAMES=2 → fg after reset; bg after the 2nd i_Frame_Start; fg again after the 4th.
- Same-cycle i_Pal_We to ID2 and a request for ID2 → that pixel shows 011_111_010; the next request shows the new colour.
- Assert i_Rst_L=0 for 1 cycle with 3 valid pixels in flight → o_Valid drops immediately and no stale pixels emerge after release. An ID1 palette write made before reset reads back as the default after reset.

Source files
------------

// File: rtl/sprite_pkg.sv
// sprite_pkg: shared mode codes, default colours and palette-entry layout helpers
package sprite_pkg;
  localparam logic [1:0] MODE_SOLID   = 2'b00;
  localparam logic [1:0] MODE_CHECKER = 2'b01;
  localparam logic [1:0] MODE_BORDER  = 2'b10;
  localparam logic [1:0] MODE_BLINK   = 2'b11;
  localparam logic [8:0] COL_YELLOW  = 9'b111_111_010;
  localparam logic [8:0] COL_LIME    = 9'b011_111_010;
  localparam logic [8:0] COL_NAVY    = 9'b000_000_001;
  localparam logic [8:0] COL_WHITE   = 9'b111_111_111;
  localparam logic [8:0] COL_MAGENTA = 9'b111_000_111;
  localparam int MAX_COLOR_WIDTH = 48;
  localparam int BG_LSB = 0;
  function automatic int fg_lsb(int cw);
    return cw;
  endfunction
  function automatic int mode_lsb(int cw);
    return 2 * cw;
  endfunction
  function automatic logic [8:0] default_col(int id);
    return id == 1 ? COL_YELLOW : id == 2 ? COL_LIME : id == 3 ? COL_NAVY :
           id == 4 ? COL_WHITE : COL_MAGENTA;
  endfunction
  // each 3-bit channel is widened by repeating its bits from the MSB down
  function automatic logic [MAX_COLOR_WIDTH-1:0] scale_col(logic [8:0] c, int cw);
    logic [MAX_COLOR_WIDTH-1:0] r;
    int chw;
    r = '0;
    chw = cw / 3;
    for (int ch = 0; ch < 3; ch++)
      for (int i = 0; i < chw; i++)
        r[ch*chw+i] = c[ch*3+2-((chw-1-i)%3)];
    return r;
  endfunction
endpackage

// File: rtl/sprite_renderer_if.sv
// sprite_renderer_if: pixel request, palette write and pixel output bundle
interface sprite_renderer_if #(
  parameter int TILE_WIDTH  = 32,
  parameter int TILE_HEIGHT = 32,
  parameter int ID_WIDTH    = 4,
  parameter int COLOR_WIDTH = 9
);
  logic                           i_Valid;
  logic [$clog2(TILE_WIDTH)-1:0]  i_X;
  logic [$clog2(TILE_HEIGHT)-1:0] i_Y;
  logic [ID_WIDTH-1:0]            i_Sprite;
  logic                           i_Frame_Start;
  logic                           i_Pal_We;
  logic [ID_WIDTH-1:0]            i_Pal_Addr;
  logic [2*COLOR_WIDTH+1:0]       i_Pal_Data;
  logic [COLOR_WIDTH-1:0]         o_Pixel;
  logic                           o_Valid;
  modport master (
    output i_Valid, i_X, i_Y, i_Sprite, i_Frame_Start, i_Pal_We, i_Pal_Addr, i_Pal_Data,
    input  o_Pixel, o_Valid
  );
  modport slave (
    input  i_Valid, i_X, i_Y, i_Sprite, i_Frame_Start, i_Pal_We, i_Pal_Addr, i_Pal_Data,
    output o_Pixel, o_Valid
  );
endinterface

// File: rtl/sprite_palette.sv
// sprite_palette: per-sprite {mode, fg, bg} register file, registered read returns pre-write data
module sprite_palette
  import sprite_pkg::*;
#(
  parameter int ID_WIDTH    = 4,
  parameter int COLOR_WIDTH = 9
) (
  input  logic                     i_Clk,
  input  logic                     i_Rst_L,
  input  logic                     i_We,
  input  logic [ID_WIDTH-1:0]      i_Waddr,
  input  logic [2*COLOR_WIDTH+1:0] i_Wdata,
  input  logic [ID_WIDTH-1:0]      i_Raddr,
  output logic [2*COLOR_WIDTH+1:0] o_Rdata
);
  localparam int DEPTH = 2 ** ID_WIDTH;
  localparam int EW = 2 * COLOR_WIDTH + 2;
  logic [EW-1:0] mem [DEPTH];
  function automatic logic [EW-1:0] dflt(int id);
    logic [COLOR_WIDTH-1:0] c;
    c = COLOR_WIDTH'(scale_col(default_col(id), COLOR_WIDTH));
    return {MODE_SOLID, c, c};
  endfunction
  always_ff @(posedge i_Clk or negedge i_Rst_L)
    if (!i_Rst_L) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= dflt(i);
      o_Rdata <= '0;
    end else begin
      if (i_We) mem[i_Waddr] <= i_Wdata;
      o_Rdata <= mem[i_Raddr];
    end
endmodule

// File: rtl/sprite_renderer.sv
// sprite_renderer: three-stage tile-sprite colour generator with palette and blink animation
module sprite_renderer
  import sprite_pkg::*;
#(
  parameter int TILE_WIDTH  = 32,
  parameter int TILE_HEIGHT = 32,
  parameter int ID_WIDTH    = 4,
  parameter int COLOR_WIDTH = 9,
  parameter int CHECK_SHIFT = 2,
  parameter int ANIM_FRAMES = 30
) (
  input  logic              i_Clk,
  input  logic              i_Rst_L,
  sprite_renderer_if.slave  bus
);
  localparam int XW = $clog2(TILE_WIDTH);
  localparam int YW = $clog2(TILE_HEIGHT);
  localparam int EW = 2 * COLOR_WIDTH + 2;
  localparam int FW = $clog2(ANIM_FRAMES + 1);
  localparam logic [FW-1:0] LAST_FRAME = FW'(ANIM_FRAMES - 1);
  logic [EW-1:0]          s1_entry;
  logic [XW-1:0]          s1_x;
  logic [YW-1:0]          s1_y;
  logic                   s1_v;
  logic [COLOR_WIDTH-1:0] s2_fg, s2_bg;
  logic                   s2_pat, s2_v;
  logic [FW-1:0]          frame_cnt;
  logic                   phase;
  logic [1:0]             s1_mode;
  logic                   on_edge, pat;
  sprite_palette #(.ID_WIDTH(ID_WIDTH), .COLOR_WIDTH(COLOR_WIDTH)) u_palette (
    .i_Clk   (i_Clk),
    .i_Rst_L (i_Rst_L),
    .i_We    (bus.i_Pal_We),
    .i_Waddr (bus.i_Pal_Addr),
    .i_Wdata (bus.i_Pal_Data),
    .i_Raddr (bus.i_Sprite),
    .o_Rdata (s1_entry)
  );
  // pat=1 selects the background colour
  always_comb begin
    s1_mode = s1_entry[mode_lsb(COLOR_WIDTH) +: 2];
    on_edge = s1_x == '0 || s1_x == XW'(TILE_WIDTH - 1) || s1_y == '0 || s1_y == YW'(TILE_HEIGHT - 1);
    pat = s1_mode == MODE_CHECKER ? s1_x[CHECK_SHIFT] ^ s1_y[CHECK_SHIFT] :
          s1_mode == MODE_BORDER  ? !on_edge :
          s1_mode == MODE_BLINK   ? phase : 1'b0;
  end
  always_ff @(posedge i_Clk or negedge i_Rst_L)
    if (!i_Rst_L) begin
      frame_cnt   <= '0;
      phase       <= 1'b0;
      s1_x        <= '0;
      s1_y        <= '0;
      s1_v        <= 1'b0;
      s2_fg       <= '0;
      s2_bg       <= '0;
      s2_pat      <= 1'b0;
      s2_v        <= 1'b0;
      bus.o_Pixel <= '0;
      bus.o_Valid <= 1'b0;
    end else begin
      if (bus.i_Frame_Start) begin
        frame_cnt <= frame_cnt == LAST_FRAME ? '0 : frame_cnt + 1'b1;
        phase     <= phase ^ (frame_cnt == LAST_FRAME);
      end
      s1_x        <= bus.i_X;
      s1_y        <= bus.i_Y;
      s1_v        <= bus.i_Valid;
      s2_fg       <= s1_entry[fg_lsb(COLOR_WIDTH) +: COLOR_WIDTH];
      s2_bg       <= s1_entry[BG_LSB +: COLOR_WIDTH];
      s2_pat      <= pat;
      s2_v        <= s1_v;
      bus.o_Valid <= s2_v;
      if (s2_v) bus.o_Pixel <= s2_pat ? s2_bg : s2_fg;
    end
endmodule

// File: tb/tb_sprite_renderer.sv
// tb_sprite_renderer: table vectors, corner sequences and random traffic against a behavioural model
module tb_sprite_renderer;
  localparam int AF = 2;
  logic clk = 1'b0;
  logic rst_l = 1'b0;
  always #5 clk = ~clk;
  sprite_renderer_if #(.TILE_WIDTH(32), .TILE_HEIGHT(32), .ID_WIDTH(4), .COLOR_WIDTH(9)) bus ();
  sprite_renderer #(
    .TILE_WIDTH(32), .TILE_HEIGHT(32), .ID_WIDTH(4), .COLOR_WIDTH(9), .CHECK_SHIFT(2), .ANIM_FRAMES(AF)
  ) dut (
    .i_Clk   (clk),
    .i_Rst_L (rst_l),
    .bus     (bus)
  );
  typedef struct {
    int s;
    int x;
    int y;
    logic [8:0] pix;
  } vec_t;
  vec_t vecs[$];
  int total = 0;
  int bad = 0;
  logic [19:0] ref_pal [16];
  int pulses;
  bit exp_v [4];
  logic [8:0] exp_p [4];
  logic [8:0] last_pix;
  int cyc;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [19:0] ref_default(int id);
    logic [8:0] c;
    c = id == 1 ? 9'h1FA : id == 2 ? 9'h0FA : id == 3 ? 9'h001 : id == 4 ? 9'h1FF : 9'h1C7;
    return {2'b00, c, c};
  endfunction

  function automatic logic [8:0] ref_colour(logic [19:0] e, int x, int y, bit ph);
    logic [8:0] fg, bg;
    fg = e[17:9];
    bg = e[8:0];
    case (e[19:18])
      2'd0: return fg;
      2'd1: return ((((x >> 2) & 1) ^ ((y >> 2) & 1)) != 0) ? bg : fg;
      2'd2: return (x == 0 || x == 31 || y == 0 || y == 31) ? fg : bg;
      default: return ph ? bg : fg;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) ref_pal[i] = ref_default(i);
    for (int i = 0; i < 4; i++) exp_v[i] = 0;
    pulses = 0;
    last_pix = '0;
    cyc = 0;
  endtask

  // one clock edge: model the request seen at this edge, then check outputs on the falling edge
  task automatic tick();
    logic [19:0] e;
    @(posedge clk);
    if (rst_l) begin
      e = ref_pal[bus.i_Sprite];
      if (bus.i_Frame_Start) pulses++;
      exp_v[(cyc+2)%4] = bus.i_Valid;
      if (bus.i_Valid) exp_p[(cyc+2)%4] = ref_colour(e, int'(bus.i_X), int'(bus.i_Y), ((pulses / AF) % 2) == 1);
      if (bus.i_Pal_We) ref_pal[bus.i_Pal_Addr] = bus.i_Pal_Data;
    end
    @(negedge clk);
    if (rst_l) begin
      check("pipe o_Valid", 32'(bus.o_Valid), 32'(exp_v[cyc%4]));
      if (exp_v[cyc%4]) last_pix = exp_p[cyc%4];
      check("pipe o_Pixel", 32'(bus.o_Pixel), 32'(last_pix));
      exp_v[cyc%4] = 0;
      cyc++;
    end else begin
      check("reset o_Valid", 32'(bus.o_Valid), 32'd0);
      check("reset o_Pixel", 32'(bus.o_Pixel), 32'd0);
    end
  endtask

  task automatic drive(bit v, int s, int x, int y);
    bus.i_Valid = v;
    bus.i_Sprite = 4'(s);
    bus.i_X = 5'(x);
    bus.i_Y = 5'(y);
    bus.i_Pal_We = 1'b0;
    bus.i_Frame_Start = 1'b0;
  endtask

  task automatic pal_write(int addr, logic [19:0] data);
    drive(0, 0, 0, 0);
    bus.i_Pal_We = 1'b1;
    bus.i_Pal_Addr = 4'(addr);
    bus.i_Pal_Data = data;
    tick();
    bus.i_Pal_We = 1'b0;
  endtask

  task automatic req_and_wait(string name, int s, int x, int y, logic [8:0] want);
    drive(1, s, x, y);
    tick();
    drive(0, 0, 0, 0);
    tick();
    tick();
    check({name, " valid"}, 32'(bus.o_Valid), 32'd1);
    check(name, 32'(bus.o_Pixel), 32'(want));
  endtask

  task automatic frame_pulse();
    drive(0, 0, 0, 0);
    bus.i_Frame_Start = 1'b1;
    tick();
    bus.i_Frame_Start = 1'b0;
  endtask

  task automatic do_reset();
    rst_l = 1'b0;
    model_reset();
    drive(0, 0, 0, 0);
    tick();
    rst_l = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    drive(0, 0, 0, 0);
    bus.i_Pal_Addr = '0;
    bus.i_Pal_Data = '0;
    model_reset();
    tick();
    tick();
    rst_l = 1'b1;
    // first request: output valid exactly on the third edge
    drive(1, 1, 0, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("latency o_Valid", 32'(bus.o_Valid), 32'(k >= 2));
      if (k == 2) check("latency pixel", 32'(bus.o_Pixel), 32'h1FA);
    end
    drive(0, 0, 0, 0);
    repeat (3) tick();
    pal_write(5, {2'b01, 9'b000_111_000, 9'b111_000_000});
    pal_write(6, {2'b10, 9'b111_111_111, 9'b000_000_000});
    vecs.push_back('{1, 0, 0, 9'h1FA});
    vecs.push_back('{9, 3, 7, 9'h1C7});
    vecs.push_back('{3, 1, 2, 9'h001});
    vecs.push_back('{4, 9, 9, 9'h1FF});
    vecs.push_back('{2, 5, 5, 9'h0FA});
    for (int x = 0; x < 8; x++) vecs.push_back('{5, x, 0, x < 4 ? 9'h038 : 9'h1C0});
    vecs.push_back('{5, 0, 4, 9'h1C0});
    vecs.push_back('{6, 0, 0, 9'h1FF});
    vecs.push_back('{6, 31, 5, 9'h1FF});
    vecs.push_back('{6, 7, 31, 9'h1FF});
    vecs.push_back('{6, 1, 1, 9'h000});
    vecs.push_back('{6, 30, 30, 9'h000});
    foreach (vecs[i]) req_and_wait($sformatf("vec%0d", i), vecs[i].s, vecs[i].x, vecs[i].y, vecs[i].pix);
    // blink follows the frame-pulse phase
    do_reset();
    pal_write(7, {2'b11, 9'h1C0, 9'h007});
    req_and_wait("blink phase0", 7, 3, 3, 9'h1C0);
    frame_pulse();
    req_and_wait("blink after 1 pulse", 7, 3, 3, 9'h1C0);
    frame_pulse();
    req_and_wait("blink after 2 pulses", 7, 3, 3, 9'h007);
    frame_pulse();
    frame_pulse();
    req_and_wait("blink after 4 pulses", 7, 3, 3, 9'h1C0);
    // same-cycle write and read of ID2 returns the old entry
    drive(1, 2, 1, 1);
    bus.i_Pal_We = 1'b1;
    bus.i_Pal_Addr = 4'd2;
    bus.i_Pal_Data = {2'b00, 9'h155, 9'h155};
    tick();
    drive(1, 2, 1, 1);
    tick();
    drive(0, 0, 0, 0);
    tick();
    check("collision old", 32'(bus.o_Pixel), 32'h0FA);
    tick();
    check("collision new", 32'(bus.o_Pixel), 32'h155);
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(3) != 0, int'($urandom_range(15)), int'($urandom_range(31)), int'($urandom_range(31)));
      bus.i_Frame_Start = $urandom_range(3) == 0;
      bus.i_Pal_We = $urandom_range(7) == 0;
      bus.i_Pal_Addr = 4'($urandom);
      bus.i_Pal_Data = 20'($urandom);
      tick();
    end
    // mid-stream reset discards in-flight pixels and restores the palette
    pal_write(1, {2'b00, 9'h00F, 9'h00F});
    for (int k = 0; k < 3; k++) begin
      drive(1, 1, k, k);
      tick();
    end
    rst_l = 1'b0;
    #1;
    check("async reset o_Valid", 32'(bus.o_Valid), 32'd0);
    check("async reset o_Pixel", 32'(bus.o_Pixel), 32'd0);
    model_reset();
    drive(0, 0, 0, 0);
    tick();
    rst_l = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("no stale valid", 32'(bus.o_Valid), 32'd0);
    end
    req_and_wait("ID1 default after reset", 1, 3, 3, 9'h1FA);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
